// File: rtl/rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_pkg
// Shared types and helpers for the four-requester round-robin bus arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT, TURN)
//   N_REQ       : number of requesters
//   onehot4()   : index -> one-hot grant vector
// ---------------------------------------------------------------------------
package rr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    localparam int N_REQ = 4;

    function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin winner selection.
// Ports:
//   req [3:0] in  : request vector
//   ptr [1:0] in  : highest-priority index; search order ptr, ptr+1, ptr+2, ptr+3
//   any       out : at least one request is set
//   idx [1:0] out : winning index (meaningful only when any=1)
// ---------------------------------------------------------------------------
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic             any,
    output logic [1:0]       idx
);

    logic [N_REQ-1:0] rot;
    logic [1:0]       off;
    logic             found;

    // Rotate so that bit 0 is the highest-priority requester, take the lowest
    // set bit, then add ptr back to recover the absolute index (2-bit wrap).
    always_comb begin
        rot   = '0;
        off   = 2'd0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[ptr + 2'(i)];
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = 2'(i);
            end
        end
        any = |req;
        idx = ptr + off;
    end

endmodule

// File: rtl/rr_bus_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_bus_arbiter4
// Four-requester shared-bus arbiter. A grant is locked until its owner drops
// req, pulses done, or reaches MAX_HOLD cycles of ownership. Priority rotates
// to the requester after the previous owner on each release. Every release is
// followed by one turnaround cycle (TURN) before arbitration resumes.
// Parameters:
//   MAX_HOLD : maximum cycles one grant may be held (>= 2)
//   HOLD_W   : hold counter width, 2**HOLD_W > MAX_HOLD
// Ports:
//   clock          in  : clock, all logic on posedge
//   reset          in  : synchronous active-high reset
//   req   [3:0]    in  : level requests, held for the whole transaction
//   done  [3:0]    in  : end-of-transaction pulses (only owner's bit used)
//   en             in  : enables new grants only
//   gnt   [3:0]    out : registered one-hot grant, 0 when idle
//   gnt_id[1:0]    out : current owner index, valid when gnt_valid=1
//   gnt_valid      out : |gnt
//   preempt        out : one-cycle pulse, aligned with gnt dropping, when the
//                        grant was ended only by the hold-time limit
// ---------------------------------------------------------------------------
module rr_bus_arbiter4
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       gnt_id,
    output logic             gnt_valid,
    output logic             preempt
);

    generate
        if (MAX_HOLD < 2 || (2 ** HOLD_W) <= MAX_HOLD) begin : g_bad_params
            $error("rr_bus_arbiter4: need MAX_HOLD >= 2 and 2**HOLD_W > MAX_HOLD");
        end
    endgenerate

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [1:0]        gnt_id_q, gnt_id_d;
    logic              preempt_q, preempt_d;

    logic              pick_any;
    logic [1:0]        pick_idx;
    logic              own_req;
    logic              own_done;
    logic              timeout;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        own_req  = req[gnt_id_q];
        own_done = done[gnt_id_q];
        timeout  = (hold_q == HOLD_LAST);
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        preempt_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en && pick_any) begin
                    gnt_d    = onehot4(pick_idx);
                    gnt_id_d = pick_idx;
                    hold_d   = '0;
                    state_d  = GRANT;
                end
            end

            GRANT: begin
                // en is deliberately ignored here: an accepted transaction
                // always runs to one of its own release conditions.
                hold_d = hold_q + HOLD_W'(1);
                if (!own_req || own_done || timeout) begin
                    gnt_d     = '0;
                    hold_d    = '0;
                    ptr_d     = gnt_id_q + 2'd1;
                    state_d   = TURN;
                    // Flag a forced release only when the owner still wanted
                    // the bus; a coincident normal end is not a preemption.
                    preempt_d = timeout && own_req && !own_done;
                end
            end

            TURN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            hold_q    <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= 2'd0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = |gnt_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_bus_arbiter4.sv
module tb_rr_bus_arbiter4;

    localparam int MAX_HOLD = 16;
    localparam int HOLD_W   = 5;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] done;
    logic       en;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    rr_bus_arbiter4 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .en        (en),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Reference model: owner (-1 when bus not owned), cycles the grant has
    // been visible, rotating priority base, and remaining turnaround cycles.
    int         m_owner = -1;
    int         m_vis   = 0;
    int         m_ptr   = 0;
    int         m_cool  = 0;
    bit         m_pre   = 0;
    logic [1:0] m_id    = 2'd0;

    task automatic model_step(input bit r, input logic [3:0] q, input logic [3:0] d, input bit e);
        bit found;
        int c;
        m_pre = 0;
        if (r) begin
            m_owner = -1; m_vis = 0; m_ptr = 0; m_cool = 0; m_id = 2'd0;
        end else if (m_owner >= 0) begin
            m_vis = m_vis + 1;
            if (!q[m_owner] || d[m_owner] || m_vis == MAX_HOLD) begin
                m_pre   = (m_vis == MAX_HOLD) && q[m_owner] && !d[m_owner];
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_cool  = 1;
            end
        end else if (m_cool > 0) begin
            m_cool = m_cool - 1;
        end else if (e && q != 4'b0000) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (!found && q[c]) begin
                    found   = 1;
                    m_owner = c;
                    m_vis   = 0;
                    m_id    = 2'(c);
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input logic [3:0] q, input logic [3:0] d, input bit e);
        logic [3:0] eg;
        reset = r; req = q; done = d; en = e;
        @(posedge clock);
        model_step(r, q, d, e);
        #1;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        check("gnt vs model", 32'(gnt), 32'(eg));
        check("gnt_valid vs model", 32'(gnt_valid), 32'(eg != 4'b0000));
        check("preempt vs model", 32'(preempt), 32'(m_pre));
        if (m_owner >= 0 || r) check("gnt_id vs model", 32'(gnt_id), 32'(m_id));
        check("gnt onehot0", 32'($onehot0(gnt)), 32'(1));
    endtask

    task automatic expect_out(input string name, input logic [3:0] g, input bit p);
        check(name, 32'(gnt), 32'(g));
        check({name, " preempt"}, 32'(preempt), 32'(p));
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] rq;
        logic [3:0] dn;
        bit         e;
        logic [3:0] g;
        bit         p;
    } vec_t;

    vec_t tbl [15];

    logic [3:0] rreq;
    logic [3:0] rdone;
    bit         rrst;
    bit         ren;

    initial begin
        reset = 1'b1; req = 4'b0000; done = 4'b0000; en = 1'b0;

        // Rotation walk with wrap 3->0, ending with a reset taken mid-grant.
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[1]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0};
        tbl[2]  = '{1'b0, 4'b1110, 4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[3]  = '{1'b0, 4'b1110, 4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[4]  = '{1'b0, 4'b1110, 4'b0000, 1'b1, 4'b0010, 1'b0};
        tbl[5]  = '{1'b0, 4'b1101, 4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[6]  = '{1'b0, 4'b1101, 4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[7]  = '{1'b0, 4'b1101, 4'b0000, 1'b1, 4'b0100, 1'b0};
        tbl[8]  = '{1'b0, 4'b1011, 4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[9]  = '{1'b0, 4'b1011, 4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[10] = '{1'b0, 4'b1011, 4'b0000, 1'b1, 4'b1000, 1'b0};
        tbl[11] = '{1'b0, 4'b0111, 4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[12] = '{1'b0, 4'b0111, 4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[13] = '{1'b0, 4'b0111, 4'b0000, 1'b1, 4'b0001, 1'b0};
        tbl[14] = '{1'b1, 4'b0111, 4'b0000, 1'b1, 4'b0000, 1'b0};

        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].rst, tbl[i].rq, tbl[i].dn, tbl[i].e);
            expect_out($sformatf("table row %0d gnt", i), tbl[i].g, tbl[i].p);
        end
        check("reset gnt_id", 32'(gnt_id), 32'(0));
        check("reset gnt_valid", 32'(gnt_valid), 32'(0));

        // Hold-time limit: exactly MAX_HOLD cycles, preempt, 2 idle, regrant.
        cycle(1, 4'b0000, 4'b0000, 1);
        cycle(0, 4'b0001, 4'b0000, 1);
        expect_out("timeout first grant", 4'b0001, 0);
        for (int i = 1; i < MAX_HOLD; i++) begin
            cycle(0, 4'b0001, 4'b0000, 1);
            expect_out("timeout held", 4'b0001, 0);
        end
        cycle(0, 4'b0001, 4'b0000, 1);
        expect_out("timeout release", 4'b0000, 1);
        cycle(0, 4'b0001, 4'b0000, 1);
        expect_out("timeout idle", 4'b0000, 0);
        cycle(0, 4'b0001, 4'b0000, 1);
        expect_out("timeout regrant", 4'b0001, 0);

        // Enable gates only new grants.
        cycle(1, 4'b0000, 4'b0000, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 4'b1111, 4'b0000, 0);
            expect_out("en low no grant", 4'b0000, 0);
        end
        cycle(0, 4'b1111, 4'b0000, 1);
        expect_out("en grant", 4'b0001, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 4'b1111, 4'b0000, 0);
            expect_out("en low grant held", 4'b0001, 0);
        end
        cycle(0, 4'b1111, 4'b0001, 0);
        expect_out("en low done release", 4'b0000, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 4'b1111, 4'b0000, 0);
            expect_out("en low after release", 4'b0000, 0);
        end

        // Non-owner done ignored; owner done rotates priority to 3.
        cycle(1, 4'b0000, 4'b0000, 1);
        cycle(0, 4'b0100, 4'b0000, 1);
        expect_out("owner2 grant", 4'b0100, 0);
        cycle(0, 4'b1111, 4'b1010, 1);
        expect_out("non-owner done", 4'b0100, 0);
        cycle(0, 4'b1111, 4'b0000, 1);
        expect_out("owner2 still", 4'b0100, 0);
        cycle(0, 4'b1111, 4'b0100, 1);
        expect_out("owner2 done", 4'b0000, 0);
        cycle(0, 4'b1111, 4'b0000, 1);
        expect_out("owner2 idle", 4'b0000, 0);
        cycle(0, 4'b1111, 4'b0000, 1);
        expect_out("next is 3", 4'b1000, 0);

        // Reset mid-grant, then priority restarts at 0.
        cycle(1, 4'b0000, 4'b0000, 1);
        cycle(0, 4'b0100, 4'b0000, 1);
        expect_out("pre-reset grant", 4'b0100, 0);
        cycle(1, 4'b0100, 4'b0000, 1);
        expect_out("reset mid-grant", 4'b0000, 0);
        cycle(0, 4'b1111, 4'b0000, 1);
        expect_out("post-reset grant", 4'b0001, 0);

        // Timeout coincident with owner done: release without preempt.
        cycle(1, 4'b0000, 4'b0000, 1);
        cycle(0, 4'b0001, 4'b0000, 1);
        for (int i = 1; i < MAX_HOLD; i++) begin
            cycle(0, 4'b0001, 4'b0000, 1);
        end
        expect_out("coincident last held", 4'b0001, 0);
        cycle(0, 4'b0001, 4'b0001, 1);
        expect_out("coincident release", 4'b0000, 0);

        // Randomized traffic against the model.
        rreq = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) rreq[b] = ~rreq[b];
            end
            for (int b = 0; b < 4; b++) begin
                rdone[b] = ($urandom_range(0, 9) == 0);
            end
            rrst = ($urandom_range(0, 299) == 0);
            ren  = ($urandom_range(0, 9) != 0);
            cycle(rrst, rreq, rdone, ren);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
